// File: rtl/hp_controller_if.sv
// Scene-side bundle for hp_controller: reload/scene control, bullet hit
// requests and player collision in; grants and the monitored counters out.
interface hp_controller_if;
  logic       gamestart;
  logic [1:0] scene;
  logic [3:0] hit_req;
  logic       player_hit;
  logic [3:0] hit_gnt;
  logic [9:0] bosshp;
  logic [1:0] life;
  logic       invincible;

  // Scene FSM / bullet logic side
  modport master (
    output gamestart, scene, hit_req, player_hit,
    input  hit_gnt, bosshp, life, invincible
  );

  // hp_controller side
  modport slave (
    input  gamestart, scene, hit_req, player_hit,
    output hit_gnt, bosshp, life, invincible
  );
endinterface

// File: rtl/hp_controller.sv
// hp_controller: boss HP and player life registers. Round-robin arbitration
// of four bullet-slot boss-hit requests with fixed damage per grant, player
// life decrement guarded by an invincibility window, reload on gamestart and
// freeze outside the game scene. All outputs are registered.
module hp_controller #(
  parameter logic [9:0]  BOSS_HP_INIT  = 10'd500,
  parameter logic [1:0]  LIFE_INIT     = 2'd3,
  parameter logic [9:0]  BULLET_DMG    = 10'd5,
  parameter logic [15:0] IFRAME_CYCLES = 16'd64
) (
  input logic           clk_22,
  input logic           rst,
  hp_controller_if.slave bus
);

  localparam logic [1:0] SCENE_GAME = 2'b01;

  typedef enum logic [1:0] {
    MODE_RELOAD,
    MODE_ACTIVE,
    MODE_FROZEN
  } mode_t;

  logic [3:0]  hit_gnt;
  logic [9:0]  bosshp;
  logic [1:0]  life;
  logic        invincible;
  logic [15:0] icnt;
  logic [1:0]  ptr;

  mode_t       mode;
  logic [3:0]  eff;
  logic        found;
  logic [1:0]  win;
  logic [1:0]  idx;
  logic [9:0]  hp_after_hit;
  logic        take_hit;

  assign bus.hit_gnt    = hit_gnt;
  assign bus.bosshp     = bosshp;
  assign bus.life       = life;
  assign bus.invincible = invincible;

  // Mode decode: reload outranks the scene check
  always_comb begin
    mode = MODE_FROZEN;
    if (bus.gamestart)
      mode = MODE_RELOAD;
    else if (bus.scene == SCENE_GAME)
      mode = MODE_ACTIVE;
  end

  // Round-robin search of the masked request vector starting at ptr
  always_comb begin
    eff   = bus.hit_req & ~hit_gnt;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + i[1:0];
      if (!found && eff[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Saturating boss damage and player-hit qualification
  always_comb begin
    hp_after_hit = (bosshp > BULLET_DMG) ? bosshp - BULLET_DMG : '0;
    take_hit     = bus.player_hit && !invincible && (life != '0);
  end

  // Counter, grant and iframe state
  always_ff @(posedge clk_22) begin
    if (rst || mode == MODE_RELOAD) begin
      bosshp     <= BOSS_HP_INIT;
      life       <= LIFE_INIT;
      hit_gnt    <= '0;
      invincible <= 1'b0;
      icnt       <= '0;
      ptr        <= '0;
    end else begin
      hit_gnt <= '0;
      // Countdown runs in both active and frozen modes; a fresh player hit
      // below can only happen while not invincible, so it never collides
      // with an in-progress countdown.
      if (invincible) begin
        if (icnt != '0)
          icnt <= icnt - 16'd1;
        else
          invincible <= 1'b0;
      end
      if (mode == MODE_ACTIVE) begin
        if (found) begin
          hit_gnt <= 4'b0001 << win;
          ptr     <= win + 2'd1;
          bosshp  <= hp_after_hit;
        end
        if (take_hit) begin
          life       <= life - 2'd1;
          invincible <= 1'b1;
          icnt       <= IFRAME_CYCLES - 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/hp_controller.md
# hp_controller

Owns the boss hit-point and player-life registers that the scene FSM monitors for win/lose. Arbitrates boss-hit requests from the four player-bullet slots round-robin, applies fixed damage per grant, and decrements player life on collision with an invincibility window. Reloads both counters whenever the scene FSM asserts `gamestart`, and freezes them outside the game scene.

## Interface
Parameters:
- `BOSS_HP_INIT`, default 10'd500: boss HP after reset or reload.
- `LIFE_INIT`, default 2'd3: player life after reset or reload.
- `BULLET_DMG`, default 10'd5: HP removed per granted boss hit.
- `IFRAME_CYCLES`, default 16'd64: invincibility length in clk_22 cycles. Must be ≥ 1.

Ports:
- `clk_22`, in, 1: system clock. All state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `gamestart`, in, 1: reload request. High while the scene FSM is in the open scene.
- `scene`, in, 2: current scene; 2'b01 = game.
- `hit_req`, in, 4: per-bullet-slot boss-hit request. Level signal, held until granted.
- `player_hit`, in, 1: player collision. Sampled each cycle.
- `hit_gnt`, out, 4: one-hot grant. Single-cycle pulse, registered.
- `bosshp`, out, 10: current boss HP, registered.
- `life`, out, 2: current player life, registered.
- `invincible`, out, 1: high during the invincibility window, registered.

## Operation
- **Reset:**
  - `bosshp`=`BOSS_HP_INIT`, `life`=`LIFE_INIT`.
  - `hit_gnt`=0, `invincible`=0.
  - Round-robin pointer `ptr`=0, iframe counter `icnt`=0.
- **Modes, by priority:** `rst` > reload > active > frozen.
- **Reload** (`gamestart`=1): same register values as reset. `hit_req` and `player_hit` are ignored.
- **Active** (`gamestart`=0, `scene`=2'b01): arbitration and damage as below.
- **Frozen** (otherwise):
  - `bosshp` and `life` hold; `hit_gnt`=0; `hit_req` and `player_hit` are ignored.
  - `icnt` and `invincible` keep counting down.
- **Arbitration (active mode):**
  - Effective request vector: `eff = hit_req & ~hit_gnt`. This masks a requester in the cycle its grant is visible.
  - Search `eff` from index `ptr` upward, modulo 4. The first set index k wins.
  - At the edge: `hit_gnt` <= onehot(k), `ptr` <= (k+1) mod 4.
  - If `eff`=0: `hit_gnt` <= 0 and `ptr` holds.
  - At most one grant per cycle.
  - A requester deasserts `hit_req` in the cycle it sees `hit_gnt`; a still-high request is arbitrated again from the next cycle.
- **Boss damage (per grant, same edge as `hit_gnt`):**
  - `bosshp` <= (`bosshp` > `BULLET_DMG`) ? `bosshp` − `BULLET_DMG` : 0. Saturates at 0; no wrap.
  - Grants continue while `bosshp`=0 so bullets still retire; `bosshp` stays 0.
- **Player damage (active mode), when `player_hit` && !`invincible` && `life`≠0:**
  - `life` <= `life` − 1.
  - `invincible` <= 1.
  - `icnt` <= `IFRAME_CYCLES` − 1.
- **Ignored player hits:** `player_hit` has no effect while `invincible`=1 or `life`=0.
- **Iframe countdown (every non-reset, non-reload cycle):**
  - If `invincible` && `icnt`≠0: `icnt` decrements.
  - If `invincible` && `icnt`=0: `invincible` <= 0.
- **Simultaneous events:**
  - A boss grant and a player hit in the same cycle are both applied.
  - `bosshp` and `life` may both reach 0 on the same edge; win priority is resolved downstream.
- **Mid-operation interruptions:**
  - `gamestart` or `rst` during an iframe window clears `invincible` and `icnt` on that edge.
  - Pending requests are dropped with no grant.

## Timing
- Request-to-grant latency: 1 cycle. `hit_req` sampled at edge N gives `hit_gnt` high from edge N to N+1; `bosshp` updates at edge N.
- Throughput: one boss hit per cycle. With all 4 requests held, the grant order from `ptr`=0 is 0,1,2,3,0,…
- `life` and `invincible` update one edge after `player_hit` is sampled.
- `invincible` is high for exactly `IFRAME_CYCLES` cycles.
- Reload takes effect on the first edge with `gamestart`=1.
- All outputs are registered with no combinational paths from inputs.

## Test plan
- **Reset/reload values:** after `rst`, check `bosshp`=500, `life`=3, `invincible`=0, `hit_gnt`=0. Damage to `bosshp`=495, then pulse `gamestart` → `bosshp`=500.
- **Round-robin fairness:** `scene`=01, hold `hit_req`=4'b1111 for 8 cycles. Required `hit_gnt` sequence: 0001, 0010, 0100, 1000, repeated. `bosshp` falls 500→460.
- **Masking and saturation:**
  - Single `hit_req[2]` held high: grants in alternate cycles only (0100, 0000, 0100…).
  - Preset HP 7 via `BOSS_HP_INIT`=7: first grant → 2, second grant → 0, third grant → 0.
- **Invincibility:** `IFRAME_CYCLES`=4.
  - `player_hit` pulse → `life` 3→2, `invincible` high for exactly 4 cycles.
  - A second `player_hit` 2 cycles later is ignored (`life` stays 2).
  - A hit after `invincible` falls → `life`=1.
- **Frozen scene:** `scene`=10 with `hit_req`=1111 and a `player_hit` pulse → `hit_gnt` stays 0, `bosshp` and `life` unchanged, running iframe still expires on schedule.
- **Simultaneous and life floor:**
  - `life`=1, `bosshp`=5, `hit_req[0]` and `player_hit` in the same cycle → next edge `bosshp`=0, `life`=0.
  - A further `player_hit` leaves `life`=0.
